// File: rtl/async_fifo_pkg.sv
// Shared types, limits and helpers for the async FIFO pointer path.
package async_fifo_pkg;

  // Synchronizer depth limits. Fewer than two flops gives too little MTBF.
  // More than four only adds latency.
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;

  // Widest pointer the shared decoder handles. Narrower pointers are
  // zero-extended on the way in. Leading zero gray bits decode to leading
  // zero binary bits, so the low bits of the result are unaffected.
  localparam int GRAY_MAX_W = 32;

  // Gray to binary decode: each binary bit is the XOR of the gray bits at
  // and above its position.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a bus. The bus must be gray coded, or it must
// change only one bit at a time. Every stage is a plain flop with nothing
// between stages, so CDC tools can identify the chain.
module sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift the asynchronous input through STAGES flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every stage is reset. The stages form a short flop array, not
      // a RAM. Resetting them ensures no stale pointer can reach the
      // decoder after reset is released.
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value
      // of its predecessor. Blocking assignments would collapse the chain
      // into a single flop.
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_rx.sv
// Receive side of a gray-coded FIFO pointer crossing. The block synchronizes
// the foreign pointer, decodes it to binary and registers it. It also
// reports the per-cycle advance, a change strobe and a sticky error that
// flags samples differing in more than one bit.
module gray_ptr_rx
  import async_fifo_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CHECK_HD    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_vld,
  output logic [WIDTH-1:0] delta,
  output logic             hd_err
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync_stages
    $error("gray_ptr_rx: SYNC_STAGES=%0d outside legal range %0d..%0d",
           SYNC_STAGES, SYNC_MIN, SYNC_MAX);
  end

  logic [WIDTH-1:0] gray_s;   // last synchronizer stage
  logic [WIDTH-1:0] gray_p;   // gray_s as it was one cycle earlier
  logic [WIDTH-1:0] bin_s;    // decoded gray_s
  logic             changed;
  logic             multi_bit;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gray_in),
    .q     (gray_s)
  );

  assign bin_s     = WIDTH'(gray2bin(GRAY_MAX_W'(gray_s)));
  assign changed   = (gray_s != gray_p);
  assign multi_bit = ($countones(gray_s ^ gray_p) > 1);

  // Register the sample history, the decoded pointer, the strobe and the
  // advance. bin_out always equals decode(gray_p), so it serves as the
  // previous binary value and no second decoder is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_p  <= '0;
      bin_out <= '0;
      bin_vld <= 1'b0;
      delta   <= '0;
    end else begin
      gray_p  <= gray_s;
      bin_out <= bin_s;
      bin_vld <= changed;
      delta   <= changed ? (bin_s - bin_out) : '0;
    end
  end

  // Sticky multi-bit-change flag. A new violation wins over a clear in the
  // same cycle. With the check disabled, the set term is constant 0 and the
  // flag stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_err <= 1'b0;
    end else if ((CHECK_HD != 0) && multi_bit) begin
      hd_err <= 1'b1;
    end else if (err_clr) begin
      hd_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Directed bench for gray_ptr_rx (WIDTH=4, SYNC_STAGES=2). Instance u_dut has
// the multi-bit check enabled. Instance u_dut_nohd has it disabled. Both see
// the same stimulus. Observed outputs are packed as {bin, vld, delta, hd}.
module tb_gray_ptr_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic         err_clr = 1'b0;

  logic [W-1:0] bin_out, delta, bin_out2, delta2;
  logic         bin_vld, hd_err, bin_vld2, hd_err2;

  logic [9:0]   obs, obs2;

  int total = 0;
  int bad   = 0;

  // Gray codes of binary 0..15, written out by hand.
  localparam logic [3:0] GRAY_OF [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  gray_ptr_rx #(.WIDTH(W), .SYNC_STAGES(2), .CHECK_HD(1)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gray_in (gray_in),
    .err_clr (err_clr),
    .bin_out (bin_out),
    .bin_vld (bin_vld),
    .delta   (delta),
    .hd_err  (hd_err)
  );

  gray_ptr_rx #(.WIDTH(W), .SYNC_STAGES(2), .CHECK_HD(0)) u_dut_nohd (
    .clk     (clk),
    .rst_n   (rst_n),
    .gray_in (gray_in),
    .err_clr (err_clr),
    .bin_out (bin_out2),
    .bin_vld (bin_vld2),
    .delta   (delta2),
    .hd_err  (hd_err2)
  );

  assign obs  = {bin_out,  bin_vld,  delta,  hd_err};
  assign obs2 = {bin_out2, bin_vld2, delta2, hd_err2};

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset both DUTs with gray_in held at g, then let g propagate fully.
  task automatic apply_reset(input logic [W-1:0] g);
    gray_in = g;
    err_clr = 1'b0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    gray_in = 4'b1011;
    err_clr = 1'b0;
    rst_n   = 1'b0;
    repeat (3) tick();
    total++;
    if (obs !== 10'b0) begin
      bad++;
      $display("FAIL reset_hold: got %b want %b", obs, 10'b0);
    end
    total++;
    if (obs2 !== 10'b0) begin
      bad++;
      $display("FAIL reset_hold_nohd: got %b want %b", obs2, 10'b0);
    end
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if (obs !== 10'b0) begin
      bad++;
      $display("FAIL reset_release_edge2: got %b want %b", obs, 10'b0);
    end
    tick();
    // Sample goes from 0000 to 1011, a 3-bit change, so the checked DUT flags it.
    total++;
    if (obs !== {4'd13, 1'b1, 4'd13, 1'b1}) begin
      bad++;
      $display("FAIL reset_release_edge3: got %b want %b", obs, {4'd13, 1'b1, 4'd13, 1'b1});
    end
    total++;
    if (obs2 !== {4'd13, 1'b1, 4'd13, 1'b0}) begin
      bad++;
      $display("FAIL reset_release_edge3_nohd: got %b want %b", obs2, {4'd13, 1'b1, 4'd13, 1'b0});
    end
    tick();
    total++;
    if (obs !== {4'd13, 1'b0, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_release_edge4: got %b want %b", obs, {4'd13, 1'b0, 4'd0, 1'b1});
    end
  endtask

  task automatic test_single_step();
    apply_reset(4'b0000);
    total++;
    if (obs !== 10'b0) begin
      bad++;
      $display("FAIL step_idle: got %b want %b", obs, 10'b0);
    end
    gray_in = 4'b0001;
    tick();
    tick();
    total++;
    if (obs !== 10'b0) begin
      bad++;
      $display("FAIL step_early: got %b want %b", obs, 10'b0);
    end
    tick();
    total++;
    if (obs !== {4'd1, 1'b1, 4'd1, 1'b0}) begin
      bad++;
      $display("FAIL step_arrive: got %b want %b", obs, {4'd1, 1'b1, 4'd1, 1'b0});
    end
    tick();
    total++;
    if (obs !== {4'd1, 1'b0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL step_hold: got %b want %b", obs, {4'd1, 1'b0, 4'd0, 1'b0});
    end
  endtask

  // Start from bin 1. Step through 2..15, wrap to 0, then 1.
  task automatic test_walk_wrap();
    logic [3:0] prev_bin;
    logic [3:0] next_bin;
    for (int k = 0; k < 16; k++) begin
      next_bin = 4'(k + 2);
      prev_bin = 4'(k + 1);
      gray_in  = GRAY_OF[next_bin];
      tick();
      tick();
      total++;
      if (obs !== {prev_bin, 1'b0, 4'd0, 1'b0}) begin
        bad++;
        $display("FAIL walk_pre[%0d]: got %b want %b", next_bin, obs, {prev_bin, 1'b0, 4'd0, 1'b0});
      end
      tick();
      total++;
      if (obs !== {next_bin, 1'b1, 4'd1, 1'b0}) begin
        bad++;
        $display("FAIL walk_step[%0d]: got %b want %b", next_bin, obs, {next_bin, 1'b1, 4'd1, 1'b0});
      end
    end
  endtask

  task automatic test_multi_jump();
    // Pointer currently at gray 0001 (bin 1). Jump to 0111 (bin 5).
    gray_in = 4'b0111;
    repeat (3) tick();
    total++;
    if (obs !== {4'd5, 1'b1, 4'd4, 1'b1}) begin
      bad++;
      $display("FAIL jump: got %b want %b", obs, {4'd5, 1'b1, 4'd4, 1'b1});
    end
    total++;
    if (obs2 !== {4'd5, 1'b1, 4'd4, 1'b0}) begin
      bad++;
      $display("FAIL jump_nohd: got %b want %b", obs2, {4'd5, 1'b1, 4'd4, 1'b0});
    end
    repeat (2) tick();
    total++;
    if (obs !== {4'd5, 1'b0, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL jump_sticky: got %b want %b", obs, {4'd5, 1'b0, 4'd0, 1'b1});
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (obs !== {4'd5, 1'b0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL err_clr: got %b want %b", obs, {4'd5, 1'b0, 4'd0, 1'b0});
    end
    // Jump back 0111 -> 0001 (bin 5 -> 1, delta 12). err_clr coincides with detection.
    gray_in = 4'b0001;
    tick();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (obs !== {4'd1, 1'b1, 4'd12, 1'b1}) begin
      bad++;
      $display("FAIL set_beats_clr: got %b want %b", obs, {4'd1, 1'b1, 4'd12, 1'b1});
    end
    total++;
    if (obs2 !== {4'd1, 1'b1, 4'd12, 1'b0}) begin
      bad++;
      $display("FAIL jump_back_nohd: got %b want %b", obs2, {4'd1, 1'b1, 4'd12, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    // 0001 -> 0100 is a 2-bit change: bin 7, and the flag sets.
    gray_in = 4'b0100;
    repeat (3) tick();
    total++;
    if (obs !== {4'd7, 1'b1, 4'd6, 1'b1}) begin
      bad++;
      $display("FAIL mid_setup: got %b want %b", obs, {4'd7, 1'b1, 4'd6, 1'b1});
    end
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 10'b0) begin
      bad++;
      $display("FAIL mid_async_clear: got %b want %b", obs, 10'b0);
    end
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if (obs !== 10'b0) begin
      bad++;
      $display("FAIL mid_pre: got %b want %b", obs, 10'b0);
    end
    tick();
    total++;
    if (obs !== {4'd7, 1'b1, 4'd7, 1'b0}) begin
      bad++;
      $display("FAIL mid_release: got %b want %b", obs, {4'd7, 1'b1, 4'd7, 1'b0});
    end
    tick();
    total++;
    if (obs !== {4'd7, 1'b0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL mid_hold: got %b want %b", obs, {4'd7, 1'b0, 4'd0, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_walk_wrap();
    test_multi_jump();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
